// File: rtl/face_pkg.sv
// Shared types and constants for the skin-mask bounding-box block.
// Coordinates are 8 bits wide and counts are 17 bits wide.
package face_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_DEPTH = 256;
    localparam int COORD_W   = 8;
    localparam int COUNT_W   = 17;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/skin_bbox_if.sv
// Raster pixel stream feeding skin_bbox.
// master drives the stream and slave receives it.
interface skin_bbox_if #(
    parameter int COLOR_DEPTH = 8
);
    logic                   frame_start;
    logic                   pix_valid;
    logic [COLOR_DEPTH-1:0] pix_in;

    modport master (
        output frame_start,
        output pix_valid,
        output pix_in
    );

    modport slave (
        input frame_start,
        input pix_valid,
        input pix_in
    );
endinterface

// File: rtl/run_filter.sv
// Per-row white run qualification.
// Flags the pixel completing a MIN_RUN run and each pixel after it.
module run_filter #(
    parameter int MIN_RUN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic white,
    input  logic valid,
    input  logic row_end,
    output logic qualify_run,
    output logic qualify_single
);
    localparam int RW = $clog2(MIN_RUN + 1);

    logic [RW-1:0] run_cnt;
    logic [RW-1:0] cur;

    // A restart makes the current pixel the first of a fresh row.
    assign cur = clr ? '0 : run_cnt;

    assign qualify_run    = valid && white && (cur == RW'(MIN_RUN - 1));
    assign qualify_single = valid && white && (cur == RW'(MIN_RUN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (valid) begin
            if (!white || row_end) begin
                run_cnt <= '0;
            end else if (cur != RW'(MIN_RUN)) begin
                run_cnt <= cur + 1'b1;
            end else begin
                run_cnt <= cur;
            end
        end else if (clr) begin
            run_cnt <= '0;
        end
    end
endmodule

// File: rtl/skin_bbox.sv
// Bounding box and count of qualified white pixels in a mask frame.
// Results load one cycle after the last pixel and hold until restart.
module skin_bbox
    import face_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int COLOR_DEPTH = 8,
    parameter int MIN_RUN     = 4,
    parameter int MIN_COUNT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    skin_bbox_if.slave  pix,
    output logic        busy,
    output logic        bbox_valid,
    output logic        face_found,
    output coord_t      x_min,
    output coord_t      x_max,
    output coord_t      y_min,
    output coord_t      y_max,
    output count_t      pix_count
);
    state_t state;
    coord_t x, y, px, py, nx, ny, run_lo, lo;
    count_t acc_cnt, n_cnt;
    coord_t acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    coord_t n_xmin, n_xmax, n_ymin, n_ymax;
    logic   start, accept, white, row_end, last;
    logic   q_run, q_single, face_next;

    assign start   = pix.frame_start;
    assign accept  = pix.pix_valid && (start || state == ACCUM);
    assign white   = pix.pix_in[COLOR_DEPTH-1];
    assign px      = start ? '0 : x;
    assign py      = start ? '0 : y;
    assign row_end = (px == COORD_W'(WIDTH - 1));
    assign last    = accept && row_end && (py == COORD_W'(DEPTH - 1));
    assign nx      = row_end ? '0 : px + 1'b1;
    assign ny      = row_end ? py + 1'b1 : py;
    assign run_lo  = px - COORD_W'(MIN_RUN - 1);
    assign lo      = q_run ? run_lo : px;

    run_filter #(
        .MIN_RUN(MIN_RUN)
    ) u_run (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (start),
        .white          (white),
        .valid          (accept),
        .row_end        (row_end),
        .qualify_run    (q_run),
        .qualify_single (q_single)
    );

    // Next accumulator values, starting from empty on a frame restart.
    always_comb begin
        n_cnt  = start ? '0 : acc_cnt;
        n_xmin = start ? '1 : acc_xmin;
        n_xmax = start ? '0 : acc_xmax;
        n_ymin = start ? '1 : acc_ymin;
        n_ymax = start ? '0 : acc_ymax;
        if (q_run || q_single) begin
            n_cnt = n_cnt + (q_run ? COUNT_W'(MIN_RUN) : COUNT_W'(1));
            if (lo < n_xmin) n_xmin = lo;
            if (px > n_xmax) n_xmax = px;
            if (py < n_ymin) n_ymin = py;
            if (py > n_ymax) n_ymax = py;
        end
    end

    assign face_next = (n_cnt >= COUNT_W'(MIN_COUNT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            acc_cnt    <= '0;
            acc_xmin   <= '1;
            acc_xmax   <= '0;
            acc_ymin   <= '1;
            acc_ymax   <= '0;
            busy       <= 1'b0;
            bbox_valid <= 1'b0;
            face_found <= 1'b0;
            pix_count  <= '0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
        end else begin
            bbox_valid <= 1'b0;
            if (start || accept) begin
                acc_cnt  <= n_cnt;
                acc_xmin <= n_xmin;
                acc_xmax <= n_xmax;
                acc_ymin <= n_ymin;
                acc_ymax <= n_ymax;
            end
            if (accept) begin
                x <= nx;
                y <= ny;
            end else if (start) begin
                x <= '0;
                y <= '0;
            end
            if (last) begin
                state      <= DONE;
                busy       <= 1'b0;
                bbox_valid <= 1'b1;
                face_found <= face_next;
                pix_count  <= n_cnt;
                x_min      <= face_next ? n_xmin : '0;
                x_max      <= face_next ? n_xmax : '0;
                y_min      <= face_next ? n_ymin : '0;
                y_max      <= face_next ? n_ymax : '0;
            end else if (start) begin
                state <= ACCUM;
                busy  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_skin_bbox.sv
// Directed bench for skin_bbox on a 140x90 frame.
// Expected results are hand-computed from the stimulus patterns.
module tb_skin_bbox;
    import face_pkg::*;

    localparam int W = 140;
    localparam int D = 90;
    localparam int N = W * D;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   busy, bbox_valid, face_found;
    coord_t x_min, x_max, y_min, y_max;
    count_t pix_count;

    int n_checks = 0;
    int n_fail = 0;
    int pulses = 0;
    int p0;

    skin_bbox_if #(.COLOR_DEPTH(8)) pif ();

    skin_bbox #(
        .WIDTH(W), .DEPTH(D), .COLOR_DEPTH(8),
        .MIN_RUN(4), .MIN_COUNT(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix        (pif),
        .busy       (busy),
        .bbox_valid (bbox_valid),
        .face_found (face_found),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bbox_valid) pulses++;

    initial begin
        #1_200_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic ff,
                           input int cnt, input int xmn, input int xmx,
                           input int ymn, input int ymx);
        chk({tag, " face"}, 32'(face_found), 32'(ff));
        chk({tag, " count"}, 32'(pix_count), cnt);
        chk({tag, " xmin"}, 32'(x_min), xmn);
        chk({tag, " xmax"}, 32'(x_max), xmx);
        chk({tag, " ymin"}, 32'(y_min), ymn);
        chk({tag, " ymax"}, 32'(y_max), ymx);
    endtask

    function automatic bit is_white(input int pat, input int x, input int y);
        case (pat)
            1: return x >= 100 && x <= 139 && y >= 50 && y <= 89;
            2: return (y % 10 == 3 && x % 20 < 3)
                   || (y == 7 && x >= 10 && x <= 13)
                   || (y == 5 && x >= 137)
                   || (y == 6 && x == 0);
            3: return y == 20 && x >= 30 && x <= 93;
            default: return 1'b0;
        endcase
    endfunction

    // Feeds pixels 0..stop_at-1; frame_start rides on the first pixel.
    task automatic send_frame(input int pat, input bit stall,
                              input int stop_at);
        int idx = 0;
        int x = 0;
        int y = 0;
        while (idx < stop_at) begin
            @(negedge clk);
            pif.frame_start = (idx == 0);
            pif.pix_valid = (idx == 0) || !stall
                || ($urandom_range(0, 1) == 1);
            pif.pix_in = 8'($urandom_range(0, 127));
            if (pif.pix_valid) begin
                if (is_white(pat, x, y)) pif.pix_in = pif.pix_in | 8'h80;
                idx++;
                x++;
                if (x == W) begin
                    x = 0;
                    y++;
                end
            end
        end
        @(negedge clk);
        pif.frame_start = 1'b0;
        pif.pix_valid = 1'b0;
    endtask

    task automatic check_pulse(input string tag);
        chk({tag, " bbox_valid"}, 32'(bbox_valid), 1);
        chk({tag, " busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, " pulse width"}, 32'(bbox_valid), 0);
    endtask

    initial begin
        pif.frame_start = 1'b0;
        pif.pix_valid = 1'b0;
        pif.pix_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset bbox_valid", 32'(bbox_valid), 0);
        chk_res("reset", 1'b0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Pixels with no frame_start in IDLE are ignored.
        @(negedge clk);
        pif.pix_valid = 1'b1;
        pif.pix_in = 8'hFF;
        repeat (2) @(negedge clk);
        pif.pix_valid = 1'b0;
        chk("idle ignore busy", 32'(busy), 0);

        send_frame(0, 1'b0, N);
        check_pulse("black");
        chk_res("black", 1'b0, 0, 0, 0, 0, 0);

        send_frame(1, 1'b0, N);
        check_pulse("rect");
        chk_res("rect", 1'b1, 1600, 100, 139, 50, 89);

        send_frame(2, 1'b0, N);
        check_pulse("runs");
        chk_res("runs", 1'b0, 4, 0, 0, 0, 0);

        send_frame(1, 1'b1, N);
        check_pulse("stall rect");
        chk_res("stall rect", 1'b1, 1600, 100, 139, 50, 89);

        // Abort mid-frame; previous results stay until the restart completes.
        p0 = pulses;
        send_frame(1, 1'b0, 6000);
        chk("abort busy", 32'(busy), 1);
        chk_res("abort held", 1'b1, 1600, 100, 139, 50, 89);
        send_frame(3, 1'b0, N);
        check_pulse("restart");
        chk_res("restart", 1'b1, 64, 30, 93, 20, 20);
        chk("restart pulses", pulses - p0, 1);

        // Reset mid-frame, asserted together with frame_start.
        p0 = pulses;
        send_frame(1, 1'b0, 3000);
        chk("pre-reset busy", 32'(busy), 1);
        rst_n = 1'b0;
        pif.frame_start = 1'b1;
        pif.pix_valid = 1'b1;
        pif.pix_in = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        pif.frame_start = 1'b0;
        chk("mid reset state", 32'(dut.state), 32'(IDLE));
        chk("mid reset busy", 32'(busy), 0);
        chk_res("mid reset", 1'b0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        pif.pix_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("post reset state", 32'(dut.state), 32'(IDLE));
        chk("post reset pulses", pulses - p0, 0);
        chk("post reset count", 32'(pix_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
